// File: rtl/icache_miss_sequencer.sv
// icache_miss_sequencer: sequences one CPU access through lookup, writeback, fill, state update and replay
module icache_miss_sequencer #(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 8
) (
   input  logic                          ACLK,
   input  logic                          ARESETn,
   input  logic                          cpu_req_valid,
   output logic                          cpu_req_ready,
   input  logic                          cpu_req_write,
   input  logic [ADDR_W-1:0]             cpu_req_addr,
   output logic                          cpu_resp_valid,
   input  logic                          lookup_hit,
   input  logic [1:0]                    lookup_way_state,
   input  logic [ADDR_W-1:0]             victim_addr,
   output logic                          state_we,
   output logic [1:0]                    state_wdata,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic                          mem_req_write,
   output logic [ADDR_W-1:0]             mem_req_addr,
   input  logic                          mem_beat_valid,
   output logic [$clog2(LINE_WORDS)-1:0] beat_idx
);
   localparam int BW = $clog2(LINE_WORDS);
   localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS * 4 - 1));
   localparam logic [1:0] ST_D = 2'b00, ST_C = 2'b01, ST_I = 2'b10;
   typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, UPDATE, RESP} state_t;
   state_t state;
   logic [ADDR_W-1:0] cap_addr;
   logic cap_write;
   logic upd_we;
   logic hit;
   logic lk_we;
   // an invalid line can never hit, whatever the tag compare says
   assign hit = lookup_hit && lookup_way_state != ST_I;
   assign lk_we = state == LOOKUP && hit && cap_write;
   assign state_we = upd_we | lk_we;
   assign state_wdata = upd_we ? ST_C : ST_D;
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= IDLE;
         cpu_req_ready <= 1'b1;
         cpu_resp_valid <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr <= '0;
         beat_idx <= '0;
         cap_addr <= '0;
         cap_write <= 1'b0;
         upd_we <= 1'b0;
      end else begin
         cpu_resp_valid <= 1'b0;
         upd_we <= 1'b0;
         case (state)
            IDLE: if (cpu_req_valid) begin
               cap_addr <= cpu_req_addr;
               cap_write <= cpu_req_write;
               cpu_req_ready <= 1'b0;
               state <= LOOKUP;
            end
            LOOKUP: if (hit) begin
               cpu_resp_valid <= 1'b1;
               state <= RESP;
            end else if (lookup_way_state == ST_D) begin
               mem_req_valid <= 1'b1;
               mem_req_write <= 1'b1;
               mem_req_addr <= victim_addr & LINE_MASK;
               state <= WB_REQ;
            end else begin
               mem_req_valid <= 1'b1;
               mem_req_write <= 1'b0;
               mem_req_addr <= cap_addr & LINE_MASK;
               state <= FILL_REQ;
            end
            WB_REQ, FILL_REQ: if (mem_req_ready) begin
               mem_req_valid <= 1'b0;
               beat_idx <= '0;
               state <= (state == WB_REQ) ? WB_DATA : FILL_DATA;
            end
            WB_DATA, FILL_DATA: if (mem_beat_valid) begin
               beat_idx <= (beat_idx == LAST) ? '0 : beat_idx + 1'b1;
               if (beat_idx == LAST && state == WB_DATA) begin
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b0;
                  mem_req_addr <= cap_addr & LINE_MASK;
                  state <= FILL_REQ;
               end else if (beat_idx == LAST) begin
                  upd_we <= 1'b1;
                  state <= UPDATE;
               end
            end
            // replay the lookup so a write now hits the freshly filled line
            UPDATE: state <= LOOKUP;
            RESP: begin
               cpu_req_ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
